// File: rtl/prom2_eval_pkg.sv
// Shared definitions for the prom2 evaluation scheduler.
//   state_t : scheduler FSM states (IDLE, SWEEP, DRAIN, DONE)
//   slot_t  : one pipeline slot {valid, is_sweep, vec}
//   VEC_W   : function input width (bit i drives xi)
//   N_VEC   : vectors per sweep (2^VEC_W)
//   CNT_W   : on-set counter width, wide enough to hold N_VEC
package prom2_eval_pkg;

    localparam int VEC_W = 8;
    localparam int N_VEC = 256;
    localparam int CNT_W = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic             valid;
        logic             is_sweep;
        logic [VEC_W-1:0] vec;
    } slot_t;

endpackage

// File: rtl/prom2_eval_sched_fn.sv
// prom2_fn: purely combinational 8-input, 1-output prom2 function.
// Interchangeable with the synthesized netlist of the same function.
//   i_x : input vector, bit i drives xi
//   o_y : function value
module prom2_fn
    import prom2_eval_pkg::*;
(
    input  logic [VEC_W-1:0] i_x,
    output logic             o_y
);

    logic w_n14;
    logic w_n16;

    assign w_n14 = ~|i_x[5:0];
    assign w_n16 = i_x[0] & (|i_x[3:1]);
    assign o_y   = (i_x[7] ^ i_x[6]) & ~((w_n14 & ~i_x[6]) | w_n16);

endmodule

// File: rtl/prom2_eval_sched.sv
// prom2_eval_sched: time-shares one prom2_fn between single-vector lookups
// and an exhaustive sweep that counts the on-set. The function input and
// output are both registered, giving a 2-cycle request-to-response latency.
//   clk, rst     : clock, synchronous active-high reset
//   req_valid    : single-vector request
//   req_ready    : request accepted when req_valid & req_ready
//   req_vec      : vector to evaluate
//   rsp_valid    : one-cycle pulse carrying a single-request result
//   rsp_bit      : function value for that request (0 when rsp_valid is low)
//   sweep_start  : start-sweep pulse, honoured only in IDLE
//   sweep_busy   : high from the cycle after an accepted start until done
//   sweep_done   : one-cycle pulse at the end of a sweep
//   ones_count   : on-set size of the last completed sweep
module prom2_eval_sched
    import prom2_eval_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [VEC_W-1:0] req_vec,
    output logic             rsp_valid,
    output logic             rsp_bit,
    input  logic             sweep_start,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic [CNT_W-1:0] ones_count
);

    state_t           r_state;
    logic [VEC_W-1:0] r_idx;
    logic             r_drain;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_ones;
    logic             r_busy;
    logic             r_done;

    slot_t            w_slot_p0;
    slot_t            r_slot_p1;
    logic             w_y_p1;
    logic             r_vld_p2;
    logic             r_swp_p2;
    logic             r_y_p2;
    logic             w_accept;

    // A start in IDLE wins over a simultaneous request.
    assign req_ready = ~rst & (r_state == IDLE) & ~sweep_start;
    assign w_accept  = req_valid & req_ready;

    // Stage 0: pick the vector entering the function this cycle
    always_comb begin
        w_slot_p0 = '0;
        if (r_state == SWEEP) begin
            w_slot_p0.valid    = 1'b1;
            w_slot_p0.is_sweep = 1'b1;
            w_slot_p0.vec      = r_idx;
        end else if (w_accept) begin
            w_slot_p0.valid    = 1'b1;
            w_slot_p0.is_sweep = 1'b0;
            w_slot_p0.vec      = req_vec;
        end
    end

    // Stage 1: registered function input feeds the combinational function
    prom2_fn u_fn (
        .i_x (r_slot_p1.vec),
        .o_y (w_y_p1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_idx           <= '0;
            r_drain         <= 1'b0;
            r_cnt           <= '0;
            r_ones          <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_slot_p1.valid <= 1'b0;
            r_vld_p2        <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_slot_p1 <= w_slot_p0;
            r_vld_p2  <= r_slot_p1.valid;

            // Stage 2 sweep results feed the on-set counter; a fresh start
            // clears it, and no sweep result can be in flight then.
            if (r_vld_p2 && r_swp_p2 && r_y_p2) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            case (r_state)
                IDLE: begin
                    if (sweep_start) begin
                        r_state <= SWEEP;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                SWEEP: begin
                    r_idx <= r_idx + VEC_W'(1);
                    if (r_idx == VEC_W'(N_VEC - 1)) begin
                        r_state <= DRAIN;
                        r_drain <= 1'b0;
                    end
                end
                DRAIN: begin
                    // Two cycles let the last vector clear both stages.
                    r_drain <= 1'b1;
                    if (r_drain) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_ones  <= r_cnt;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Stage 2: registered function output
    always_ff @(posedge clk) begin
        r_swp_p2 <= r_slot_p1.is_sweep;
        r_y_p2   <= w_y_p1;
    end

    assign rsp_valid  = r_vld_p2 & ~r_swp_p2;
    assign rsp_bit    = rsp_valid & r_y_p2;
    assign sweep_busy = r_busy;
    assign sweep_done = r_done;
    assign ones_count = r_ones;

endmodule

// File: tb/tb_prom2_eval_sched.sv
// Bench for prom2_eval_sched: directed stimulus, a cycle-count based model of
// the scheduler's observable behaviour, and a per-cycle compare on negedge.
module tb_prom2_eval_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_vec;
    logic       rsp_valid;
    logic       rsp_bit;
    logic       sweep_start;
    logic       sweep_busy;
    logic       sweep_done;
    logic [8:0] ones_count;

    always #5 clk = ~clk;

    prom2_eval_sched dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_vec     (req_vec),
        .rsp_valid   (rsp_valid),
        .rsp_bit     (rsp_bit),
        .sweep_start (sweep_start),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done),
        .ones_count  (ones_count)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference function, written arithmetically from the boolean definition.
    function automatic int f_model(input int x);
        int b[8];
        int low_all_zero;
        int n16;
        for (int i = 0; i < 8; i++) b[i] = (x >> i) & 1;
        low_all_zero = ((x % 64) == 0) ? 1 : 0;
        n16 = (b[0] == 1 && (b[1] + b[2] + b[3]) > 0) ? 1 : 0;
        if (b[7] == b[6]) return 0;
        if (low_all_zero == 1 && b[6] == 0) return 0;
        if (n16 == 1) return 0;
        return 1;
    endfunction

    function automatic int model_ones();
        int s = 0;
        for (int v = 0; v < 256; v++) s += f_model(v);
        return s;
    endfunction

    // Model: m_sw counts cycles since the accepted start edge (-1 = not sweeping).
    typedef struct { int due; int b; } rsp_t;
    rsp_t q[$];
    int   cyc    = 0;
    int   m_sw   = -1;
    int   m_done = 0;
    int   m_ones = 0;
    int   m_init = 0;
    int   done_seen = 0;
    int   obs[$];

    always @(posedge clk) begin : model
        int acc;
        cyc++;
        if (rst) begin
            m_sw = -1; m_done = 0; m_ones = 0; m_init = 1;
            q.delete();
        end else begin
            acc = (req_valid && m_sw < 0 && !sweep_start) ? 1 : 0;
            m_done = 0;
            if (m_sw >= 0) begin
                m_sw++;
                if (m_sw == 259) begin
                    m_sw = -1; m_done = 1; m_ones = model_ones();
                end
            end else if (sweep_start) begin
                m_sw = 0;
            end
            if (acc == 1) q.push_back('{cyc + 1, f_model(int'(req_vec))});
        end
    end

    always @(negedge clk) begin : compare
        int exp_v;
        int exp_b;
        if (m_init == 1) begin
            exp_v = (q.size() > 0 && q[0].due == cyc) ? 1 : 0;
            exp_b = (exp_v == 1) ? q[0].b : 0;
            if (exp_v == 1) void'(q.pop_front());
            chk("req_ready",  int'(req_ready),  (!rst && m_sw < 0 && !sweep_start) ? 1 : 0);
            chk("rsp_valid",  int'(rsp_valid),  exp_v);
            if (exp_v == 1) chk("rsp_bit", int'(rsp_bit), exp_b);
            chk("sweep_busy", int'(sweep_busy), (m_sw >= 0) ? 1 : 0);
            chk("sweep_done", int'(sweep_done), m_done);
            chk("ones_count", int'(ones_count), m_ones);
            if (rsp_valid) obs.push_back(int'(rsp_bit));
            if (sweep_done) done_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] vecs[7];
    int         exp1[7];

    initial begin
        rst = 1'b1; req_valid = 1'b0; sweep_start = 1'b0; req_vec = 8'h00;
        vecs = '{8'h40, 8'h41, 8'h43, 8'h80, 8'h90, 8'hC0, 8'h00};
        exp1 = '{1, 1, 0, 0, 1, 0, 0};

        // Hand-computed pins on the model itself
        for (int i = 0; i < 7; i++) chk("model_f", f_model(int'(vecs[i])), exp1[i]);
        chk("model_ones", model_ones(), 71);

        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Back-to-back single requests
        obs.delete();
        for (int i = 0; i < 7; i++) begin
            req_valid = 1'b1; req_vec = vecs[i];
            tick();
        end
        req_valid = 1'b0;
        repeat (4) tick();
        chk("b2b_count", obs.size(), 7);
        for (int i = 0; i < 7 && i < obs.size(); i++) chk("b2b_bit", obs[i], exp1[i]);

        // Plain sweep
        done_seen = 0;
        sweep_start = 1'b1; tick(); sweep_start = 1'b0;
        repeat (262) tick();
        chk("sweep1_ones", int'(ones_count), 71);
        chk("sweep1_done", done_seen, 1);

        // Request in flight when sweep starts
        obs.delete(); done_seen = 0;
        req_valid = 1'b1; req_vec = 8'h43; tick();
        req_valid = 1'b0; sweep_start = 1'b1; tick(); sweep_start = 1'b0;
        repeat (262) tick();
        chk("inflight_count", obs.size(), 1);
        if (obs.size() > 0) chk("inflight_bit", obs[0], 0);
        chk("sweep2_ones", int'(ones_count), 71);
        chk("sweep2_done", done_seen, 1);

        // Start and request together: sweep wins, request held until after DONE
        obs.delete(); done_seen = 0;
        sweep_start = 1'b1; req_valid = 1'b1; req_vec = 8'h40; tick();
        sweep_start = 1'b0;
        repeat (260) tick();
        req_valid = 1'b0;
        repeat (4) tick();
        chk("collide_count", obs.size(), 1);
        if (obs.size() > 0) chk("collide_bit", obs[0], 1);
        chk("sweep3_done", done_seen, 1);

        // Reset mid-sweep
        done_seen = 0;
        sweep_start = 1'b1; tick(); sweep_start = 1'b0;
        repeat (99) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (270) tick();
        chk("abort_done", done_seen, 0);
        chk("abort_ones", int'(ones_count), 0);
        sweep_start = 1'b1; tick(); sweep_start = 1'b0;
        repeat (262) tick();
        chk("sweep4_ones", int'(ones_count), 71);
        chk("sweep4_done", done_seen, 1);

        // Extra start during SWEEP is ignored
        done_seen = 0;
        sweep_start = 1'b1; tick(); sweep_start = 1'b0;
        repeat (50) tick();
        sweep_start = 1'b1; tick(); sweep_start = 1'b0;
        repeat (225) tick();
        chk("sweep5_ones", int'(ones_count), 71);
        chk("sweep5_done", done_seen, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
